// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the RAM macro and mem_arbiter.
// The arbiter takes the master modport; the requesters and RAM take slave.
interface mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_lock;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;
   logic [1:0]        owner;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
      input  mem_rdata,
      output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
      output mem_addr, mem_wdata, mem_we, mem_re, owner
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
      output mem_rdata,
      input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
      input  mem_addr, mem_wdata, mem_we, mem_re, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA onto the shared RAM with a 4-cycle access FSM.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants under contention.
module mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.master bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [1:0]        owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              we_q;
   logic              mem_we_q;
   logic              mem_re_q;
   logic              cpu_ack_q;
   logic              dma_ack_q;
   logic              lock_q;

   logic              any_req;
   logic              dma_first;
   logic              grant_dma;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_dma_q;

   // Contended grant goes to whoever did not win last time.
   assign dma_first = !last_dma_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_dma_q <= 1'b0;
      end else if (state_q == S_IDLE && any_req) begin
         last_dma_q <= grant_dma;
      end
   end
`else
   assign dma_first = 1'b1;
`endif

   assign any_req   = bus.cpu_req | bus.dma_req;
   assign grant_dma = bus.dma_req &
                      (lock_q | !bus.cpu_req | dma_first);
   assign sel_we    = grant_dma ? bus.dma_we    : bus.cpu_we;
   assign sel_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
   assign sel_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (any_req) state_d = S_ACCESS;
         S_ACCESS: state_d = S_WAIT;
         S_WAIT:   state_d = S_DONE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         we_q        <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         lock_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_we_q  <= 1'b0;
         mem_re_q  <= 1'b0;
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!bus.dma_lock || !bus.dma_req) lock_q <= 1'b0;
               if (any_req) begin
                  owner_q  <= grant_dma ? OWN_DMA : OWN_CPU;
                  addr_q   <= sel_addr;
                  wdata_q  <= sel_wdata;
                  we_q     <= sel_we;
                  mem_we_q <= sel_we;
                  mem_re_q <= !sel_we;
               end
            end
            S_ACCESS: ;
            S_WAIT: begin
               // RAM data is valid the cycle after the read strobe.
               if (!we_q) begin
                  if (owner_q == OWN_DMA) dma_rdata_q <= bus.mem_rdata;
                  else                    cpu_rdata_q <= bus.mem_rdata;
               end
               cpu_ack_q <= (owner_q == OWN_CPU);
               dma_ack_q <= (owner_q == OWN_DMA);
            end
            default: begin
               if (owner_q == OWN_DMA && bus.dma_lock) lock_q <= 1'b1;
               owner_q <= OWN_NONE;
            end
         endcase
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.owner     = owner_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences
// and a randomized run against a transaction-level model.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   logic ram_clr;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // RAM behaviour: one-cycle read latency, garbage when not reading.
   logic [15:0] ram [4096];
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 4096; i++) ram[i] <= '0;
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
      else            bus.mem_rdata <= 16'($urandom);
   end

   typedef struct {
      bit          is_dma;
      bit          we;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } vec_t;

   vec_t        tbl [8];
   logic [15:0] exp_crd, exp_drd;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.cpu_req = 0; bus.cpu_we = 0;
      bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_we = 0;
      bus.dma_addr = '0; bus.dma_wdata = '0;
      bus.dma_lock = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_owner"}, bus.owner, 0);
      chk({tag, "_we"}, bus.mem_we, 0);
      chk({tag, "_re"}, bus.mem_re, 0);
      chk({tag, "_cack"}, bus.cpu_ack, 0);
      chk({tag, "_dack"}, bus.dma_ack, 0);
      chk({tag, "_addr"}, bus.mem_addr, 0);
      chk({tag, "_wdata"}, bus.mem_wdata, 0);
      chk({tag, "_crd"}, bus.cpu_rdata, 0);
      chk({tag, "_drd"}, bus.dma_rdata, 0);
   endtask

   task automatic drive(input vec_t v);
      if (v.is_dma) begin
         bus.dma_req = 1; bus.dma_we = v.we;
         bus.dma_addr = v.addr; bus.dma_wdata = v.wdata;
      end else begin
         bus.cpu_req = 1; bus.cpu_we = v.we;
         bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
      end
   endtask

   // One uncontended transfer starting from IDLE; ends in the next IDLE.
   task automatic single(input vec_t v);
      logic [1:0] own;
      own = v.is_dma ? 2'b10 : 2'b01;
      drive(v);
      step();
      chk("acc_we", bus.mem_we, v.we);
      chk("acc_re", bus.mem_re, !v.we);
      chk("acc_addr", bus.mem_addr, v.addr);
      chk("acc_wdata", bus.mem_wdata, v.wdata);
      chk("acc_owner", bus.owner, own);
      step();
      chk("wait_we", bus.mem_we, 0);
      chk("wait_re", bus.mem_re, 0);
      chk("wait_owner", bus.owner, own);
      chk("wait_ack", bus.cpu_ack | bus.dma_ack, 0);
      step();
      if (!v.we && v.is_dma) exp_drd = v.rdata;
      if (!v.we && !v.is_dma) exp_crd = v.rdata;
      chk("done_cack", bus.cpu_ack, !v.is_dma);
      chk("done_dack", bus.dma_ack, v.is_dma);
      chk("done_owner", bus.owner, own);
      chk("done_crd", bus.cpu_rdata, exp_crd);
      chk("done_drd", bus.dma_rdata, exp_drd);
      if (v.is_dma) bus.dma_req = 0;
      else          bus.cpu_req = 0;
      step();
      chk("idle_owner", bus.owner, 0);
      chk("idle_ack", bus.cpu_ack | bus.dma_ack, 0);
      chk("idle_strobe", bus.mem_we | bus.mem_re, 0);
   endtask

   // Both requesters active; acks recorded as 1=CPU, 2=DMA.
   task automatic contend(input string tag, input bit lock,
                          input int e0, input int e1,
                          input int e2, input int e3);
      int got [4];
      int want [4];
      int n = 0;
      int ndma = 0;
      int cyc = 0;
      int last_t = 0;
      want[0] = e0; want[1] = e1; want[2] = e2; want[3] = e3;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h012;
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 12'hFFF;
      bus.dma_lock = lock;
      while (n < 4 && cyc < 40) begin
         step();
         cyc++;
         chk({tag, "_excl"}, bus.cpu_ack & bus.dma_ack, 0);
         if (bus.cpu_ack || bus.dma_ack) begin
            got[n] = bus.dma_ack ? 2 : 1;
            if (n > 0) chk({tag, "_gap"}, cyc - last_t, 4);
            last_t = cyc;
            if (bus.dma_ack) ndma++;
            if (lock && ndma == 3) begin
               bus.dma_req = 0; bus.dma_lock = 0;
            end
            if (lock && bus.cpu_ack) bus.cpu_req = 0;
            n++;
         end
      end
      bus.cpu_req = 0; bus.dma_req = 0; bus.dma_lock = 0;
      chk({tag, "_count"}, n, 4);
      for (int i = 0; i < n; i++) chk({tag, "_order"}, got[i], want[i]);
      step();
      chk({tag, "_owner_end"}, bus.owner, 0);
   endtask

   // Transaction-level model state for the randomized run.
   bit          m_act, m_dma, m_we, m_lock, m_last_dma;
   int          g_edge;
   logic [11:0] m_addr;
   logic [15:0] m_rd, e_addr_wd;
   logic [11:0] e_addr;
   logic [15:0] shadow [16];
   bit          cpend, dpend;

   initial begin
      vec_t v;
      bit   pick_dma, e_cack, e_dack;
      int   p;
      logic [1:0] e_own;
      tbl[0] = '{1, 1, 12'hFFF, 16'h1234, 16'h0000};
      tbl[1] = '{0, 0, 12'hFFF, 16'h0001, 16'h1234};
      tbl[2] = '{0, 1, 12'h012, 16'hBEEF, 16'h0000};
      tbl[3] = '{0, 0, 12'h012, 16'h0002, 16'hBEEF};
      tbl[4] = '{1, 0, 12'h012, 16'h0003, 16'hBEEF};
      tbl[5] = '{1, 1, 12'h000, 16'hA5A5, 16'h0000};
      tbl[6] = '{0, 0, 12'h000, 16'h0004, 16'hA5A5};
      tbl[7] = '{0, 0, 12'h7FF, 16'h0005, 16'h0000};

      idle_inputs();
      rst_n = 0; ram_clr = 1;
      step(); step();
      chk_reset("rst");
      rst_n = 1; ram_clr = 0;
      exp_crd = '0; exp_drd = '0;

      for (int i = 0; i < 8; i++) single(tbl[i]);

`ifdef MEM_ARB_ROUND_ROBIN_EN
      contend("contend", 0, 2, 1, 2, 1);
`else
      contend("contend", 0, 2, 2, 2, 2);
`endif
      contend("lock", 1, 2, 2, 2, 1);

      // DMA drops its request during WAIT; the transfer still completes.
      v = '{1, 0, 12'h012, 16'h0000, 16'hBEEF};
      drive(v);
      step();
      chk("drop_re", bus.mem_re, 1);
      step();
      bus.dma_req = 0;
      step();
      chk("drop_dack", bus.dma_ack, 1);
      chk("drop_drd", bus.dma_rdata, 16'hBEEF);
      step();
      chk("drop_owner", bus.owner, 0);
      for (int i = 0; i < 3; i++) begin
         chk("drop_quiet", bus.mem_we | bus.mem_re | bus.dma_ack, 0);
         step();
      end

      // Reset lands in ACCESS of a CPU write.
      v = '{0, 1, 12'h055, 16'h7777, 16'h0000};
      drive(v);
      step();
      chk("rstacc_we", bus.mem_we, 1);
      rst_n = 0;
      step();
      chk_reset("rstacc");
      step();
      chk("rstacc_noack", bus.cpu_ack, 0);
      rst_n = 1;
      exp_crd = '0; exp_drd = '0;
      single(v);
      v = '{0, 0, 12'h055, 16'h0000, 16'h7777};
      single(v);

      // Randomized run against the transaction-level model.
      idle_inputs();
      rst_n = 0; ram_clr = 1;
      step(); step();
      rst_n = 1; ram_clr = 0;
      for (int i = 0; i < 16; i++) shadow[i] = '0;
      m_act = 0; m_lock = 0; m_last_dma = 0; g_edge = 0;
      e_addr = '0; e_addr_wd = '0; exp_crd = '0; exp_drd = '0;
      cpend = 0; dpend = 0;
      for (int k = 0; k < 1500; k++) begin
         @(posedge clk);
         if (m_act) begin
            if (k == g_edge + 3) begin
               if (m_dma && bus.dma_lock) m_lock = 1;
               m_act = 0;
            end
         end else begin
            if (bus.dma_req && m_lock) pick_dma = 1;
            else if (bus.dma_req && bus.cpu_req)
`ifdef MEM_ARB_ROUND_ROBIN_EN
               pick_dma = !m_last_dma;
`else
               pick_dma = 1;
`endif
            else pick_dma = bus.dma_req;
            if (!bus.dma_lock || !bus.dma_req) m_lock = 0;
            if (bus.cpu_req || bus.dma_req) begin
               m_act = 1; g_edge = k; m_dma = pick_dma;
               m_last_dma = pick_dma;
               m_we = pick_dma ? bus.dma_we : bus.cpu_we;
               m_addr = pick_dma ? bus.dma_addr : bus.cpu_addr;
               e_addr = m_addr;
               e_addr_wd = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
               if (m_we) shadow[m_addr[3:0]] = e_addr_wd;
               else      m_rd = shadow[m_addr[3:0]];
            end
         end
         @(negedge clk);
         p = k - g_edge;
         e_own = !m_act ? 2'b00 : (m_dma ? 2'b10 : 2'b01);
         e_cack = m_act && p == 2 && !m_dma;
         e_dack = m_act && p == 2 && m_dma;
         if (m_act && p == 2 && !m_we) begin
            if (m_dma) exp_drd = m_rd;
            else       exp_crd = m_rd;
         end
         chk("rnd_owner", bus.owner, e_own);
         chk("rnd_we", bus.mem_we, m_act && p == 0 && m_we);
         chk("rnd_re", bus.mem_re, m_act && p == 0 && !m_we);
         chk("rnd_cack", bus.cpu_ack, e_cack);
         chk("rnd_dack", bus.dma_ack, e_dack);
         chk("rnd_addr", bus.mem_addr, e_addr);
         chk("rnd_wdata", bus.mem_wdata, e_addr_wd);
         chk("rnd_crd", bus.cpu_rdata, exp_crd);
         chk("rnd_drd", bus.dma_rdata, exp_drd);
         if (e_cack) begin cpend = 0; bus.cpu_req = 0; end
         if (e_dack) begin dpend = 0; bus.dma_req = 0; end
         if (!cpend && $urandom_range(0, 2) == 0) begin
            cpend = 1; bus.cpu_req = 1;
            bus.cpu_we = 1'($urandom_range(0, 1));
            bus.cpu_addr = 12'($urandom_range(0, 15));
            bus.cpu_wdata = 16'($urandom);
         end
         if (!dpend && $urandom_range(0, 2) == 0) begin
            dpend = 1; bus.dma_req = 1;
            bus.dma_we = 1'($urandom_range(0, 1));
            bus.dma_addr = 12'($urandom_range(0, 15));
            bus.dma_wdata = 16'($urandom);
         end
         bus.dma_lock = ($urandom_range(0, 2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
